// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: accepts parallel words, optionally pulses the detector reset,
// shifts each word MSB-first into the sequence detector, and collects the
// detector's Z output per bit into a mask. A saturating hit counter tracks
// the total number of Z=1 captures.
//
// Handshakes: a transfer happens on any clk edge where valid and ready are
// both high. in_valid/in_ready accepts a word (in_ready is high only in
// IDLE). out_valid/out_ready returns the mask (out_valid is high only in
// DONE). out_mask is held stable while out_valid is high.
module fsm_seq_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8,
    parameter int Z_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_restart,
    output logic              in_ready,
    output logic              det_x,
    output logic              det_step,
    output logic              det_rst,
    input  logic              det_z,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_mask,
    input  logic              out_ready,
    input  logic              clear,
    output logic [CNT_W-1:0]  hit_count,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORD_W - 1);
    localparam logic [2:0]       DRAIN_LAST = 3'(Z_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_cnt;
    logic [2:0]        drain_cnt;
    logic              accept;

    // Tag pipeline that follows each stepped bit until its Z appears on det_z.
    logic              pipe_vld [Z_LAT];
    logic [IDX_W-1:0]  pipe_idx [Z_LAT];
    logic              cap;
    logic [IDX_W-1:0]  cap_idx;

    assign accept    = (state_q == S_IDLE) && in_valid;
    assign cap       = pipe_vld[Z_LAT-1];
    assign cap_idx   = pipe_idx[Z_LAT-1];
    assign det_rst   = reset || (state_q == S_RST);
    assign dbg_state = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        det_step  = 1'b0;
        det_x     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = in_restart ? S_RST : S_SHIFT;
            end
            S_RST: state_d = S_SHIFT;
            S_SHIFT: begin
                det_step = 1'b1;
                det_x    = shreg[WORD_W-1];
                if (bit_cnt == LAST_IDX) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shift register, bit counter and drain counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg   <= in_data;
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    shreg     <= shreg << 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                    drain_cnt <= '0;
                end
                S_DRAIN: drain_cnt <= drain_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Tag pipeline: bit index of the word that each stepped bit belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Z_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= det_step;
            pipe_idx[0] <= LAST_IDX - bit_cnt;
            for (int i = 1; i < Z_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    // Detection mask: cleared on accept, filled as tagged bits emerge.
    always_ff @(posedge clk) begin
        if (reset)       out_mask <= '0;
        else if (accept) out_mask <= '0;
        else if (cap)    out_mask[cap_idx] <= det_z;
    end

    // Saturating hit counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || clear)
            hit_count <= '0;
        else if (cap && det_z && (hit_count != {CNT_W{1'b1}}))
            hit_count <= hit_count + 1'b1;
    end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl: two instances (Z latency 1 with an echo stub and
// Z latency 3 with a plain delay line), directed scenarios then random words.
module tb_fsm_seq_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_restart = 1'b0;
  logic         out_ready = 1'b0;
  logic         clear = 1'b0;
  logic         use3 = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         in_ready1, det_x1, det_step1, det_rst1, out_valid1, busy1;
  logic         det_z1 = 1'b0;
  logic [W-1:0] out_mask1;
  logic [3:0]   hit1;
  logic [2:0]   dbg1;

  logic         in_ready3, det_x3, det_step3, det_rst3, det_z3, out_valid3, busy3;
  logic [W-1:0] out_mask3;
  logic [7:0]   hit3;
  logic [2:0]   dbg3;
  logic [2:0]   zl3 = '0;

  fsm_seq_ctrl #(.WORD_W(W), .CNT_W(4), .Z_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid & ~use3), .in_data(in_data),
    .in_restart(in_restart), .in_ready(in_ready1), .det_x(det_x1),
    .det_step(det_step1), .det_rst(det_rst1), .det_z(det_z1),
    .out_valid(out_valid1), .out_mask(out_mask1), .out_ready(out_ready & ~use3),
    .clear(clear), .hit_count(hit1), .busy(busy1), .dbg_state(dbg1)
  );

  fsm_seq_ctrl #(.WORD_W(W), .CNT_W(8), .Z_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid & use3), .in_data(in_data),
    .in_restart(in_restart), .in_ready(in_ready3), .det_x(det_x3),
    .det_step(det_step3), .det_rst(det_rst3), .det_z(det_z3),
    .out_valid(out_valid3), .out_mask(out_mask3), .out_ready(out_ready & use3),
    .clear(clear), .hit_count(hit3), .busy(busy3), .dbg_state(dbg3)
  );

  // Echo detector stub: Z follows X one cycle after a step.
  always @(posedge clk) if (det_step1) det_z1 <= det_x1;

  // Three-cycle delay detector stub.
  always @(posedge clk) zl3 <= {zl3[1:0], det_x3};
  assign det_z3 = zl3[2];

  // Observed view of whichever instance is under test.
  logic         o_ready, o_x, o_step, o_rst, o_valid, o_busy;
  logic [W-1:0] o_mask;
  logic [7:0]   o_hit;
  always_comb begin
    o_ready = in_ready1; o_x = det_x1; o_step = det_step1; o_rst = det_rst1;
    o_valid = out_valid1; o_busy = busy1; o_mask = out_mask1; o_hit = {4'b0, hit1};
    if (use3) begin
      o_ready = in_ready3; o_x = det_x3; o_step = det_step3; o_rst = det_rst3;
      o_valid = out_valid3; o_busy = busy3; o_mask = out_mask3; o_hit = hit3;
    end
  end

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int exp_hit1 = 0;
  int exp_hit3 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full word transaction on the selected instance, with model checks.
  task automatic run_word(input logic [W-1:0] w, input logic rs, input int stall,
                          input int clr_cyc, input logic hold_valid);
    int lat, cmax, cyc, n_rst, first_step, n_step, wait_n, cur, cnt, first;
    logic [W-1:0] xs;
    logic [W-1:0] exp_mask;
    lat = use3 ? 3 : 1;
    cmax = use3 ? 255 : 15;
    wait_n = 0;
    while (!o_ready && wait_n < 50) begin
      tick();
      wait_n++;
    end
    check("idle_before_accept", 32'(o_ready), 1);
    in_valid = 1'b1;
    in_data = w;
    in_restart = rs;
    exp_q.push_back(w);
    tick();
    in_valid = hold_valid;
    in_data = W'($urandom);
    in_restart = 1'($urandom);
    check("mask_cleared_on_accept", 32'(o_mask), 0);
    cyc = 1; n_rst = 0; first_step = 0; n_step = 0; xs = '0;
    while (cyc < 40 && !o_valid) begin
      if (o_rst) n_rst++;
      if (o_step) begin
        if (n_step == 0) first_step = cyc;
        if (n_step < W) xs[W-1-n_step] = o_x;
        n_step++;
      end
      clear = (cyc == clr_cyc);
      if (hold_valid) in_data = W'($urandom);
      tick();
      cyc++;
      if (clr_cyc > 0 && cyc == clr_cyc + 1) check("hit_zero_after_clear", 32'(o_hit), 0);
    end
    clear = 1'b0;
    check("out_valid_seen", 32'(o_valid), 1);
    check("done_cycle", 32'(cyc), 32'(W + 1 + lat + (rs ? 1 : 0)));
    check("rst_pulses", 32'(n_rst), rs ? 1 : 0);
    check("first_step_cycle", 32'(first_step), rs ? 2 : 1);
    check("step_count", 32'(n_step), W);
    check("serial_bits", 32'(xs), 32'(w));
    check("busy_in_done", 32'(o_busy), 1);
    check("ready_in_done", 32'(o_ready), 0);
    exp_mask = exp_q.pop_front();
    check("mask", 32'(o_mask), 32'(exp_mask));
    first = rs ? 2 : 1;
    if (clr_cyc > 0) begin
      cnt = 0;
      for (int j = 0; j < W; j++)
        if (w[W-1-j] && (first + j + lat > clr_cyc)) cnt++;
      cur = cnt;
      if (use3) exp_hit1 = 0; else exp_hit3 = 0;
    end else begin
      cur = (use3 ? exp_hit3 : exp_hit1) + $countones(w);
    end
    if (cur > cmax) cur = cmax;
    if (use3) exp_hit3 = cur; else exp_hit1 = cur;
    check("hit_count", 32'(o_hit), 32'(cur));
    for (int s = 0; s < stall; s++) begin
      tick();
      check("mask_hold", 32'(o_mask), 32'(exp_mask));
      check("valid_hold", 32'(o_valid), 1);
      check("ready_low_in_stall", 32'(o_ready), 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("valid_drop", 32'(o_valid), 0);
    check("ready_after_done", 32'(o_ready), 1);
    check("busy_after_done", 32'(o_busy), 0);
  endtask

  initial begin
    int nv;
    logic [W-1:0] w;
    // Reset state.
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready1), 1);
    check("rst_det_x", 32'(det_x1), 0);
    check("rst_det_step", 32'(det_step1), 0);
    check("rst_det_rst", 32'(det_rst1), 1);
    check("rst_out_valid", 32'(out_valid1), 0);
    check("rst_out_mask", 32'(out_mask1), 0);
    check("rst_hit", 32'(hit1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_hit3", 32'(hit3), 0);
    reset = 1'b0;
    tick();
    check("det_rst_released", 32'(det_rst1), 0);

    // Directed words on the latency-1 instance.
    run_word(8'hA5, 1'b1, 0, 0, 1'b0);
    run_word(8'hFF, 1'b0, 5, 0, 1'b0);

    // Saturation with a 4-bit counter.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    exp_hit1 = 0; exp_hit3 = 0;
    run_word(8'hFF, 1'b0, 0, 0, 1'b0);
    run_word(8'hFF, 1'b1, 0, 0, 1'b1);
    // Clear lands on a cycle with a Z=1 capture.
    run_word(8'hFF, 1'b0, 0, 5, 1'b0);

    // Latency-3 instance.
    use3 = 1'b1;
    run_word(8'h81, 1'b1, 0, 0, 1'b0);
    run_word(8'h3C, 1'b0, 2, 0, 1'b1);
    use3 = 1'b0;

    // Reset during SHIFT after three bits.
    in_valid = 1'b1; in_data = 8'hFF; in_restart = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", 32'(in_ready1), 1);
    check("abort_busy", 32'(busy1), 0);
    check("abort_step", 32'(det_step1), 0);
    check("abort_hit", 32'(hit1), 0);
    check("abort_mask", 32'(out_mask1), 0);
    exp_hit1 = 0; exp_hit3 = 0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid1) nv++;
      tick();
    end
    check("abort_no_out_valid", 32'(nv), 0);

    // Random words against the model.
    for (int k = 0; k < 16; k++) begin
      use3 = 1'($urandom_range(0, 1));
      w = W'($urandom);
      run_word(w, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? $urandom_range(2, 9) : 0,
               1'($urandom_range(0, 1)));
    end
    use3 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
